// File: rtl/asynchronous_fifo_pkg.sv
// Shared definitions for the Gray-pointer FIFO demonstrator.
//   DATA_W_DEF / ADDR_W_DEF / READ_DIV_DEF : default geometry and read-strobe period
//   bin2gray                               : binary to reflected-Gray conversion
package async_fifo_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned READ_DIV_DEF = 10;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/asynchronous_fifo_if.sv
// Observation bundle for the FIFO demonstrator outputs.
//   data_out : last word popped
//   r_empty  : read-side empty flag
//   w_full   : write-side full flag
// master = the FIFO driving the bundle, slave = any observer.
interface asynchronous_fifo_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] data_out;
    logic              r_empty;
    logic              w_full;

    modport master (output data_out, output r_empty, output w_full);
    modport slave  (input  data_out, input  r_empty, input  w_full);
endinterface

// File: rtl/asynchronous_fifo_sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
//   clk_i : clock
//   rst_i : synchronous reset, clears both stages
//   d_i   : value to synchronize
//   q_o   : value delayed by two clock edges
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] ff1_q;
    logic [WIDTH-1:0] ff2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/asynchronous_fifo.sv
// Self-stimulating Gray-pointer FIFO. A counter writes 0,1,2,... whenever
// the FIFO is not full; a divided read strobe pops one word every READ_DIV
// clocks. Both sides share one clock but keep the two-flop pointer
// synchronizers of a clock-domain-crossing FIFO so flag latency matches it.
//   write_clk : the single clock (rising edge)
//   reset     : synchronous, active-high
//   data_out  : last word popped (registered)
//   r_empty   : empty as seen by the read side (registered, pessimistic)
//   w_full    : full as seen by the write side (registered, pessimistic)
// ADDR_W must be at least 2 for the full-flag comparison.
module asynchronous_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned READ_DIV = READ_DIV_DEF
) (
    input  logic              write_clk,
    input  logic              reset,
    output logic [DATA_W-1:0] data_out,
    output logic              r_empty,
    output logic              w_full
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [PTR_W-1:0]  wbin_q,     wbin_d;
    logic [PTR_W-1:0]  rbin_q,     rbin_d;
    logic [PTR_W-1:0]  wgray_q,    wgray_d;
    logic [PTR_W-1:0]  rgray_q,    rgray_d;
    logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              r_empty_q,  r_empty_d;
    logic              w_full_q,   w_full_d;

    logic [PTR_W-1:0]  wq2;
    logic [PTR_W-1:0]  rq2;
    logic [PTR_W-1:0]  rq2_full_cmp;
    logic              wr_en;
    logic              rd_tick;
    logic              rd_en;

    sync_2ff #(.WIDTH(PTR_W)) u_sync_w2r (
        .clk_i (write_clk),
        .rst_i (reset),
        .d_i   (wgray_q),
        .q_o   (wq2)
    );

    sync_2ff #(.WIDTH(PTR_W)) u_sync_r2w (
        .clk_i (write_clk),
        .rst_i (reset),
        .d_i   (rgray_q),
        .q_o   (rq2)
    );

    // Enables are gated by the registered flags, so overflow/underflow
    // cannot occur.
    assign wr_en   = ~w_full_q;
    assign rd_tick = (rd_cnt_q == CNT_W'(READ_DIV - 1));
    assign rd_en   = rd_tick & ~r_empty_q;

    // Full when the write pointer is one lap ahead: Gray form inverts the
    // two MSBs of the synchronized read pointer.
    assign rq2_full_cmp = {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]};

    always_comb begin
        wdata_d    = wdata_q;
        wbin_d     = wbin_q;
        rbin_d     = rbin_q;
        data_out_d = data_out_q;
        rd_cnt_d   = rd_tick ? '0 : rd_cnt_q + CNT_W'(1);

        if (wr_en) begin
            wdata_d = wdata_q + DATA_W'(1);
            wbin_d  = wbin_q + PTR_W'(1);
        end
        if (rd_en) begin
            data_out_d = mem[rbin_q[ADDR_W-1:0]];
            rbin_d     = rbin_q + PTR_W'(1);
        end

        wgray_d   = PTR_W'(bin2gray(32'(wbin_d)));
        rgray_d   = PTR_W'(bin2gray(32'(rbin_d)));
        r_empty_d = (rgray_d == wq2);
        w_full_d  = (wgray_d == rq2_full_cmp);
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            wdata_q    <= '0;
            wbin_q     <= '0;
            rbin_q     <= '0;
            wgray_q    <= '0;
            rgray_q    <= '0;
            rd_cnt_q   <= '0;
            data_out_q <= '0;
            r_empty_q  <= 1'b1;
            w_full_q   <= 1'b0;
        end else begin
            wdata_q    <= wdata_d;
            wbin_q     <= wbin_d;
            rbin_q     <= rbin_d;
            wgray_q    <= wgray_d;
            rgray_q    <= rgray_d;
            rd_cnt_q   <= rd_cnt_d;
            data_out_q <= data_out_d;
            r_empty_q  <= r_empty_d;
            w_full_q   <= w_full_d;
        end
    end

    // Storage has no reset; stale contents are never read because the
    // pointers restart together.
    always_ff @(posedge write_clk) begin
        if (!reset && wr_en) begin
            mem[wbin_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    assign data_out = data_out_q;
    assign r_empty  = r_empty_q;
    assign w_full   = w_full_q;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Bench for asynchronous_fifo: one instance at READ_DIV=10 with a fixed and
// several random reset pulses, one at READ_DIV=1. Both are compared every
// cycle against a count-based model: the k-th word popped is k, a flag sees
// the other side's count three edges late, empty when counts match, full
// when they differ by the depth.
module tb_asynchronous_fifo;
    import async_fifo_pkg::*;

    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NCYC   = 2100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    asynchronous_fifo_if #(.DATA_W(DW)) bus_a ();
    asynchronous_fifo_if #(.DATA_W(DW)) bus_b ();

    asynchronous_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_DIV(10)) dut_a (
        .write_clk (clk),
        .reset     (rst_a),
        .data_out  (bus_a.data_out),
        .r_empty   (bus_a.r_empty),
        .w_full    (bus_a.w_full)
    );

    asynchronous_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_DIV(1)) dut_b (
        .write_clk (clk),
        .reset     (rst_b),
        .data_out  (bus_b.data_out),
        .r_empty   (bus_b.r_empty),
        .w_full    (bus_b.w_full)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int unsigned div    [2] = '{10, 1};
    int unsigned m_wr   [2];
    int unsigned m_rd   [2];
    int unsigned m_edge [2];
    int unsigned wh     [2][3];
    int unsigned rh     [2][3];
    logic        m_full [2];
    logic        m_empty[2];
    logic [DW-1:0] m_dout[2];

    task automatic model_step(input int i, input logic rst);
        logic do_wr;
        logic do_rd;
        if (rst) begin
            m_wr[i] = 0; m_rd[i] = 0; m_edge[i] = 0;
            for (int k = 0; k < 3; k++) begin
                wh[i][k] = 0;
                rh[i][k] = 0;
            end
            m_full[i]  = 1'b0;
            m_empty[i] = 1'b1;
            m_dout[i]  = '0;
        end else begin
            m_edge[i]++;
            do_wr = !m_full[i];
            do_rd = ((m_edge[i] % div[i]) == 0) && !m_empty[i];
            if (do_rd) begin
                m_dout[i] = DW'(m_rd[i]);
                m_rd[i]++;
            end
            if (do_wr) m_wr[i]++;
            m_empty[i] = (m_rd[i] == wh[i][2]);
            m_full[i]  = ((m_wr[i] - rh[i][2]) == DEPTH);
            wh[i][2] = wh[i][1]; wh[i][1] = wh[i][0]; wh[i][0] = m_wr[i];
            rh[i][2] = rh[i][1]; rh[i][1] = rh[i][0]; rh[i][0] = m_rd[i];
        end
    endtask

    initial begin
        int unsigned rnd_at;
        int unsigned rnd_len;
        int unsigned a_changes;
        int unsigned a_rises_obs;
        int unsigned a_rises_exp;
        logic [DW-1:0] a_prev_dout;
        logic a_prev_full;
        logic m_prev_full;
        int unsigned b_full_seen;
        int unsigned b_empty_again;
        int unsigned b_bad_step;
        int unsigned b_drained_samples;
        logic [DW-1:0] b_prev_dout;

        rnd_at  = 600 + $urandom_range(0, 300);
        rnd_len = $urandom_range(1, 3);
        a_changes = 0; a_rises_obs = 0; a_rises_exp = 0;
        a_prev_dout = '0; a_prev_full = 1'b0; m_prev_full = 1'b0;
        b_full_seen = 0; b_empty_again = 0; b_bad_step = 0;
        b_drained_samples = 0; b_prev_dout = '0;

        for (int c = 0; c < int'(NCYC); c++) begin
            cyc = c;
            rst_a = (c < 4) || (c == 157) ||
                    (c >= int'(rnd_at) && c < int'(rnd_at + rnd_len));
            rst_b = (c < 4);
            if (c == int'(rnd_at + rnd_len)) begin
                rnd_at  = rnd_at + $urandom_range(300, 500);
                rnd_len = $urandom_range(1, 3);
            end

            @(posedge clk);
            model_step(0, rst_a);
            model_step(1, rst_b);
            @(negedge clk);

            check_eq("a_data_out", 32'(bus_a.data_out), 32'(m_dout[0]));
            check_eq("a_r_empty",  32'(bus_a.r_empty),  32'(m_empty[0]));
            check_eq("a_w_full",   32'(bus_a.w_full),   32'(m_full[0]));
            check_eq("b_data_out", 32'(bus_b.data_out), 32'(m_dout[1]));
            check_eq("b_r_empty",  32'(bus_b.r_empty),  32'(m_empty[1]));
            check_eq("b_w_full",   32'(bus_b.w_full),   32'(m_full[1]));

            // Fixed restart point: first pop after the cycle-157 pulse is 0,
            // then 1 and 2 on following read periods.
            if (c == 157 + 10) check_eq("restart_pop0", 32'(bus_a.data_out), 32'd0);
            if (c == 157 + 20) check_eq("restart_pop1", 32'(bus_a.data_out), 32'd1);
            if (c == 157 + 30) check_eq("restart_pop2", 32'(bus_a.data_out), 32'd2);
            if (c == 4 + 9)    check_eq("first_pop1",   32'(bus_a.data_out), 32'd0);
            if (c == 4 + 19)   check_eq("first_pop2",   32'(bus_a.data_out), 32'd1);

            if (!rst_a) begin
                if (bus_a.data_out != a_prev_dout) a_changes++;
                if (c >= 200 && bus_a.w_full && !a_prev_full) a_rises_obs++;
                if (c >= 200 && m_full[0] && !m_prev_full) a_rises_exp++;
            end
            a_prev_dout = bus_a.data_out;
            a_prev_full = bus_a.w_full;
            m_prev_full = m_full[0];

            if (!rst_b) begin
                if (bus_b.w_full) b_full_seen++;
                if (b_drained_samples > 0 && bus_b.r_empty) b_empty_again++;
                if (b_drained_samples >= 2 && bus_b.data_out != DW'(b_prev_dout + DW'(1)))
                    b_bad_step++;
                if (!bus_b.r_empty || b_drained_samples > 0) b_drained_samples++;
            end
            b_prev_dout = bus_b.data_out;
        end

        check_eq("a_wraps_over_20", 32'((a_changes / DEPTH) > 20), 32'd1);
        check_eq("a_full_rises",    a_rises_obs, a_rises_exp);
        check_eq("b_full_never",    b_full_seen, 32'd0);
        check_eq("b_empty_never",   b_empty_again, 32'd0);
        check_eq("b_consecutive",   b_bad_step, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
